// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags (busy + ROB index).
// Reads are combinational with a same-cycle commit bypass; x0 is hardwired to zero.
module reg_file #(
  parameter int REG_NUM   = 32,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 roll_back,
  input  logic                 de_rename_en,
  input  logic [4:0]           de_rename_rd,
  input  logic [ROB_IDX_W-1:0] de_rename_rob_idx,
  input  logic [4:0]           rs1_idx,
  input  logic [4:0]           rs2_idx,
  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_dep,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_dep,
  output logic [DATA_W-1:0]    rs2_val,
  input  logic                 rf_in_en,
  input  logic [ROB_IDX_W-1:0] rf_rob_idx_in,
  input  logic [4:0]           rf_dest_in,
  input  logic [DATA_W-1:0]    rf_val_in
);

  logic [DATA_W-1:0]    val_r  [REG_NUM];
  logic                 busy_r [REG_NUM];
  logic [ROB_IDX_W-1:0] dep_r  [REG_NUM];

  logic commit_ok;
  logic rename_ok;
  logic commit_clears;

  assign commit_ok     = rf_in_en && (rf_dest_in != 5'd0);
  assign rename_ok     = de_rename_en && !roll_back && (de_rename_rd != 5'd0);
  // Only the newest writer's commit may release the tag; an older one leaves it alone.
  assign commit_clears = busy_r[rf_dest_in] && (dep_r[rf_dest_in] == rf_rob_idx_in);

  // State update: commit writes value, rename overrides tag, roll_back clears all tags.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_r[i]  <= {DATA_W{1'b0}};
        busy_r[i] <= 1'b0;
        dep_r[i]  <= {ROB_IDX_W{1'b0}};
      end
    end else if (rdy_in) begin
      if (commit_ok) begin
        val_r[rf_dest_in] <= rf_val_in;
        if (commit_clears) begin
          busy_r[rf_dest_in] <= 1'b0;
        end
      end
      if (roll_back) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_r[i] <= 1'b0;
          dep_r[i]  <= {ROB_IDX_W{1'b0}};
        end
      end else if (rename_ok) begin
        busy_r[de_rename_rd] <= 1'b1;
        dep_r[de_rename_rd]  <= de_rename_rob_idx;
      end
    end
  end

  // Source 1 lookup with commit bypass; same-cycle renames are deliberately not visible.
  always_comb begin
    rs1_busy = 1'b0;
    rs1_dep  = {ROB_IDX_W{1'b0}};
    rs1_val  = {DATA_W{1'b0}};
    if (rs1_idx == 5'd0) begin
      rs1_busy = 1'b0;
    end else if (rf_in_en && (rf_dest_in == rs1_idx) && busy_r[rs1_idx] &&
                 (dep_r[rs1_idx] == rf_rob_idx_in)) begin
      rs1_val = rf_val_in;
    end else begin
      rs1_busy = busy_r[rs1_idx];
      rs1_dep  = busy_r[rs1_idx] ? dep_r[rs1_idx] : {ROB_IDX_W{1'b0}};
      rs1_val  = val_r[rs1_idx];
    end
  end

  // Source 2 lookup, identical to source 1.
  always_comb begin
    rs2_busy = 1'b0;
    rs2_dep  = {ROB_IDX_W{1'b0}};
    rs2_val  = {DATA_W{1'b0}};
    if (rs2_idx == 5'd0) begin
      rs2_busy = 1'b0;
    end else if (rf_in_en && (rf_dest_in == rs2_idx) && busy_r[rs2_idx] &&
                 (dep_r[rs2_idx] == rf_rob_idx_in)) begin
      rs2_val = rf_val_in;
    end else begin
      rs2_busy = busy_r[rs2_idx];
      rs2_dep  = busy_r[rs2_idx] ? dep_r[rs2_idx] : {ROB_IDX_W{1'b0}};
      rs2_val  = val_r[rs2_idx];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: rename/commit/bypass, roll_back, x0, stall, async reset.
module tb_reg_file;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        de_rename_en;
  logic [4:0]  de_rename_rd;
  logic [3:0]  de_rename_rob_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        rs1_busy;
  logic [3:0]  rs1_dep;
  logic [31:0] rs1_val;
  logic        rs2_busy;
  logic [3:0]  rs2_dep;
  logic [31:0] rs2_val;
  logic        rf_in_en;
  logic [3:0]  rf_rob_idx_in;
  logic [4:0]  rf_dest_in;
  logic [31:0] rf_val_in;

  int checks = 0;
  int errors = 0;

  reg_file dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .de_rename_en(de_rename_en), .de_rename_rd(de_rename_rd),
    .de_rename_rob_idx(de_rename_rob_idx),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs1_dep(rs1_dep), .rs1_val(rs1_val),
    .rs2_busy(rs2_busy), .rs2_dep(rs2_dep), .rs2_val(rs2_val),
    .rf_in_en(rf_in_en), .rf_rob_idx_in(rf_rob_idx_in),
    .rf_dest_in(rf_dest_in), .rf_val_in(rf_val_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] idx);
    de_rename_en = 1'b1; de_rename_rd = rd; de_rename_rob_idx = idx;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] idx, input logic [31:0] v);
    rf_in_en = 1'b1; rf_dest_in = rd; rf_rob_idx_in = idx; rf_val_in = v;
  endtask

  task automatic idle();
    de_rename_en = 1'b0; rf_in_en = 1'b0; roll_back = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
    de_rename_en = 1'b0; de_rename_rd = 5'd0; de_rename_rob_idx = 4'd0;
    rf_in_en = 1'b0; rf_dest_in = 5'd0; rf_rob_idx_in = 4'd0; rf_val_in = 32'd0;
    rs1_idx = 5'd0; rs2_idx = 5'd0;
    #12 rst_in = 1'b0;
    step();

    // 1: reset state
    rs1_idx = 5'd5; rs2_idx = 5'd0; #1;
    chk("rst_rs1_busy", rs1_busy, 0); chk("rst_rs1_dep", rs1_dep, 0); chk("rst_rs1_val", rs1_val, 0);
    chk("rst_rs2_busy", rs2_busy, 0); chk("rst_rs2_dep", rs2_dep, 0); chk("rst_rs2_val", rs2_val, 0);

    // 2: rename x3 -> rob 7, then commit with bypass
    rename(5'd3, 4'd7); step(); idle();
    rs1_idx = 5'd3; #1;
    chk("ren_busy", rs1_busy, 1); chk("ren_dep", rs1_dep, 7);
    commit(5'd3, 4'd7, 32'h1234); #1;
    chk("byp_busy", rs1_busy, 0); chk("byp_dep", rs1_dep, 0); chk("byp_val", rs1_val, 32'h1234);
    step(); idle(); #1;
    chk("cmt_busy", rs1_busy, 0); chk("cmt_val", rs1_val, 32'h1234);

    // 3: two writers to x4, older commit must not clear tag
    rename(5'd4, 4'd2); step(); rename(5'd4, 4'd5); step(); idle();
    commit(5'd4, 4'd2, 32'hAA); rs1_idx = 5'd4; #1;
    chk("old_byp_busy", rs1_busy, 1); chk("old_byp_dep", rs1_dep, 5);
    step(); idle(); #1;
    chk("old_val", rs1_val, 32'hAA); chk("old_busy", rs1_busy, 1); chk("old_dep", rs1_dep, 5);
    commit(5'd4, 4'd5, 32'hBB); step(); idle(); #1;
    chk("new_busy", rs1_busy, 0); chk("new_val", rs1_val, 32'hBB);

    // 4: commit and rename x6 in the same cycle
    rename(5'd6, 4'd9); step(); idle();
    commit(5'd6, 4'd9, 32'h66); rename(5'd6, 4'd10); rs1_idx = 5'd6; #1;
    chk("same_byp_busy", rs1_busy, 0); chk("same_byp_val", rs1_val, 32'h66);
    step(); idle(); #1;
    chk("same_val", rs1_val, 32'h66); chk("same_busy", rs1_busy, 1); chk("same_dep", rs1_dep, 10);

    // 5: roll_back with simultaneous rename (dropped) and commit (kept)
    rename(5'd1, 4'd1); step(); rename(5'd2, 4'd2); step(); rename(5'd8, 4'd3); step(); idle();
    rs1_idx = 5'd8; #1;
    chk("pre_rb_busy", rs1_busy, 1);
    roll_back = 1'b1; rename(5'd9, 4'd4); commit(5'd8, 4'd3, 32'h88);
    step(); idle();
    rs1_idx = 5'd1; rs2_idx = 5'd2; #1;
    chk("rb_x1_busy", rs1_busy, 0); chk("rb_x2_busy", rs2_busy, 0); chk("rb_x2_dep", rs2_dep, 0);
    rs1_idx = 5'd8; rs2_idx = 5'd9; #1;
    chk("rb_x8_busy", rs1_busy, 0); chk("rb_x8_val", rs1_val, 32'h88); chk("rb_x9_busy", rs2_busy, 0);
    rs1_idx = 5'd3; rs2_idx = 5'd4; #1;
    chk("rb_x3_val", rs1_val, 32'h1234); chk("rb_x4_val", rs2_val, 32'hBB);

    // 6a: x0 is immutable
    commit(5'd0, 4'd0, 32'hFFFF); rename(5'd0, 4'd6); rs1_idx = 5'd0; #1;
    chk("x0_byp_val", rs1_val, 0); chk("x0_byp_busy", rs1_busy, 0);
    step(); idle(); #1;
    chk("x0_busy", rs1_busy, 0); chk("x0_dep", rs1_dep, 0); chk("x0_val", rs1_val, 0);

    // 6b: rdy_in low freezes state
    rdy_in = 1'b0; rename(5'd5, 4'd11); commit(5'd3, 4'd1, 32'h5555);
    step(); idle(); rdy_in = 1'b1;
    rs1_idx = 5'd5; rs2_idx = 5'd3; #1;
    chk("stall_busy", rs1_busy, 0); chk("stall_val", rs2_val, 32'h1234);

    // 6c: asynchronous reset between edges, then fresh rename with wrapped-range index
    rename(5'd10, 4'd12); step(); idle();
    rs1_idx = 5'd10; rs2_idx = 5'd4; #1;
    chk("prerst_busy", rs1_busy, 1);
    #1 rst_in = 1'b1; #1;
    chk("arst_busy", rs1_busy, 0); chk("arst_dep", rs1_dep, 0); chk("arst_val", rs2_val, 0);
    rst_in = 1'b0;
    rename(5'd10, 4'd15); step(); idle(); #1;
    chk("post_busy", rs1_busy, 1); chk("post_dep", rs1_dep, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
